// File: rtl/morse_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | morse_pkg : shared types and letter codes for the Morse decoder     |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package morse_pkg;

    typedef logic [4:0] letter_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        BAD     = 2'd2
    } state_t;

    localparam int MAX_SYMS = 4;

    localparam letter_t LTR_A = 5'd0,  LTR_B = 5'd1,  LTR_C = 5'd2,  LTR_D = 5'd3,
                        LTR_E = 5'd4,  LTR_F = 5'd5,  LTR_G = 5'd6,  LTR_H = 5'd7,
                        LTR_I = 5'd8,  LTR_J = 5'd9,  LTR_K = 5'd10, LTR_L = 5'd11,
                        LTR_M = 5'd12, LTR_N = 5'd13, LTR_O = 5'd14, LTR_P = 5'd15,
                        LTR_Q = 5'd16, LTR_R = 5'd17, LTR_S = 5'd18, LTR_T = 5'd19,
                        LTR_U = 5'd20, LTR_V = 5'd21, LTR_W = 5'd22, LTR_X = 5'd23,
                        LTR_Y = 5'd24, LTR_Z = 5'd25;

endpackage : morse_pkg
`default_nettype wire

// File: rtl/morse_lut.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | morse_lut : combinational (pattern, length) -> letter lookup        |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module morse_lut
    import morse_pkg::*;
(
    input  logic [3:0] pattern,
    input  logic [2:0] len,
    output letter_t    letter,
    output logic       legal
);

    // Pattern is right-aligned: the first keyed symbol sits at bit len-1, dash=1.
    always_comb begin
        letter = LTR_A;
        legal  = 1'b1;
        case ({len, pattern})
            {3'd1, 4'b0000}: letter = LTR_E;
            {3'd1, 4'b0001}: letter = LTR_T;
            {3'd2, 4'b0001}: letter = LTR_A;
            {3'd2, 4'b0000}: letter = LTR_I;
            {3'd2, 4'b0011}: letter = LTR_M;
            {3'd2, 4'b0010}: letter = LTR_N;
            {3'd3, 4'b0100}: letter = LTR_D;
            {3'd3, 4'b0110}: letter = LTR_G;
            {3'd3, 4'b0101}: letter = LTR_K;
            {3'd3, 4'b0111}: letter = LTR_O;
            {3'd3, 4'b0010}: letter = LTR_R;
            {3'd3, 4'b0000}: letter = LTR_S;
            {3'd3, 4'b0001}: letter = LTR_U;
            {3'd3, 4'b0011}: letter = LTR_W;
            {3'd4, 4'b1000}: letter = LTR_B;
            {3'd4, 4'b1010}: letter = LTR_C;
            {3'd4, 4'b0010}: letter = LTR_F;
            {3'd4, 4'b0000}: letter = LTR_H;
            {3'd4, 4'b0111}: letter = LTR_J;
            {3'd4, 4'b0100}: letter = LTR_L;
            {3'd4, 4'b0110}: letter = LTR_P;
            {3'd4, 4'b1101}: letter = LTR_Q;
            {3'd4, 4'b0001}: letter = LTR_V;
            {3'd4, 4'b1001}: letter = LTR_X;
            {3'd4, 4'b1011}: letter = LTR_Y;
            {3'd4, 4'b1100}: letter = LTR_Z;
            default:         legal  = 1'b0;
        endcase
    end

endmodule : morse_lut
`default_nettype wire

// File: rtl/morse_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | morse_decoder : assembles dot/dash pulses into letters, detects     |
// |                 letter and word gaps by counting idle cycles        |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
module morse_decoder
    import morse_pkg::*;
#(
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 7,
    parameter int CNT_W      = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       dot,
    input  logic       dash,
    output letter_t    letter,
    output logic       letter_valid,
    output logic       letter_err,
    output logic       word_sep,
    output logic [2:0] sym_count
);

    localparam logic [CNT_W-1:0] C_LETTER_LAST = CNT_W'(LETTER_GAP - 1);
    localparam logic [CNT_W-1:0] C_WORD_LAST   = CNT_W'(WORD_GAP - 1);
    localparam logic [CNT_W-1:0] C_WORD_GAP    = CNT_W'(WORD_GAP);

    state_t           state_q, state_d;
    logic [3:0]       pattern_q, pattern_d;
    logic [2:0]       sym_count_q, sym_count_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             word_armed_q, word_armed_d;
    letter_t          letter_q, letter_d;
    logic             letter_valid_q, letter_valid_d;
    logic             letter_err_q, letter_err_d;
    logic             word_sep_q, word_sep_d;

    letter_t          w_lut_letter;
    logic             w_lut_legal;
    logic             w_sym;

    morse_lut u_lut (
        .pattern (pattern_q),
        .len     (sym_count_q),
        .letter  (w_lut_letter),
        .legal   (w_lut_legal)
    );

    assign w_sym = dot | dash;

    always_comb begin
        state_d        = state_q;
        pattern_d      = pattern_q;
        sym_count_d    = sym_count_q;
        idle_cnt_d     = idle_cnt_q;
        word_armed_d   = word_armed_q;
        letter_d       = letter_q;
        letter_valid_d = 1'b0;
        letter_err_d   = 1'b0;
        word_sep_d     = 1'b0;

        if (w_sym) begin
            // Any keyed symbol restarts gap timing, even on the closing cycle.
            idle_cnt_d   = '0;
            word_armed_d = 1'b0;
            if (dot && dash) begin
                state_d = BAD;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d     = COLLECT;
                        pattern_d   = {3'b000, dash};
                        sym_count_d = 3'd1;
                    end
                    COLLECT: begin
                        if (sym_count_q == 3'(MAX_SYMS)) begin
                            state_d = BAD;
                        end else begin
                            pattern_d   = {pattern_q[2:0], dash};
                            sym_count_d = sym_count_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            if (idle_cnt_q != C_WORD_GAP) begin
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
            if ((idle_cnt_q == C_LETTER_LAST) && (state_q != IDLE)) begin
                if ((state_q == COLLECT) && w_lut_legal) begin
                    letter_d       = w_lut_letter;
                    letter_valid_d = 1'b1;
                end else begin
                    letter_err_d   = 1'b1;
                end
                state_d      = IDLE;
                pattern_d    = '0;
                sym_count_d  = '0;
                word_armed_d = 1'b1;
            end else if ((idle_cnt_q == C_WORD_LAST) && word_armed_q) begin
                word_sep_d   = 1'b1;
                word_armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q        <= IDLE;
            pattern_q      <= '0;
            sym_count_q    <= '0;
            idle_cnt_q     <= '0;
            word_armed_q   <= 1'b0;
            letter_q       <= LTR_A;
            letter_valid_q <= 1'b0;
            letter_err_q   <= 1'b0;
            word_sep_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pattern_q      <= pattern_d;
            sym_count_q    <= sym_count_d;
            idle_cnt_q     <= idle_cnt_d;
            word_armed_q   <= word_armed_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            letter_err_q   <= letter_err_d;
            word_sep_q     <= word_sep_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = letter_valid_q;
    assign letter_err   = letter_err_q;
    assign word_sep     = word_sep_q;
    assign sym_count    = sym_count_q;

endmodule : morse_decoder
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_morse_decoder : directed and random stimulus against a           |
// |                    string-based Morse reference model               |
// | Revision         : 1.0                                              |
// +--------------------------------------------------------------------+
module tb_morse_decoder;

    localparam int LG = 3;
    localparam int WG = 7;

    logic       Clock;
    logic       Reset;
    logic       dot;
    logic       dash;
    logic [4:0] letter;
    logic       letter_valid;
    logic       letter_err;
    logic       word_sep;
    logic [2:0] sym_count;

    int n_cmp = 0;
    int n_err = 0;
    int sep_seen;

    morse_decoder #(
        .LETTER_GAP (LG),
        .WORD_GAP   (WG),
        .CNT_W      (4)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .dot          (dot),
        .dash         (dash),
        .letter       (letter),
        .letter_valid (letter_valid),
        .letter_err   (letter_err),
        .word_sep     (word_sep),
        .sym_count    (sym_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: the current letter is kept as a string of '.'/'-'.
    string morse_tbl [0:25] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                                "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                                "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                                "-.--", "--.."};
    string      m_seq;
    bit         m_bad;
    int         m_idle;
    bit         m_armed;
    logic [4:0] m_letter;
    logic       m_valid, m_err, m_sep;

    function automatic int lookup(string s);
        for (int i = 0; i < 26; i++) begin
            if (morse_tbl[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_seq = ""; m_bad = 1'b0; m_idle = 0; m_armed = 1'b0;
        m_letter = 5'd0; m_valid = 1'b0; m_err = 1'b0; m_sep = 1'b0;
    endtask

    task automatic model_edge(input bit d, input bit da);
        int prev;
        int idx;
        m_valid = 1'b0; m_err = 1'b0; m_sep = 1'b0;
        if (d || da) begin
            m_idle  = 0;
            m_armed = 1'b0;
            if (d && da) m_bad = 1'b1;
            else if (!m_bad) begin
                if (m_seq.len() == 4) m_bad = 1'b1;
                else if (d) m_seq = {m_seq, "."};
                else m_seq = {m_seq, "-"};
            end
        end else begin
            prev = m_idle;
            if (m_idle < WG) m_idle++;
            if (m_idle == LG && prev != m_idle && (m_bad || m_seq.len() > 0)) begin
                idx = lookup(m_seq);
                if (!m_bad && idx >= 0) begin
                    m_letter = 5'(idx);
                    m_valid  = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_seq = ""; m_bad = 1'b0; m_armed = 1'b1;
            end else if (m_idle == WG && prev != WG && m_armed) begin
                m_sep   = 1'b1;
                m_armed = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        n_cmp++;
        assert (letter === m_letter) else begin
            n_err++; $error("FAIL %s letter observed=%0d expected=%0d", tag, letter, m_letter);
        end
        n_cmp++;
        assert (letter_valid === m_valid) else begin
            n_err++; $error("FAIL %s letter_valid observed=%b expected=%b", tag, letter_valid, m_valid);
        end
        n_cmp++;
        assert (letter_err === m_err) else begin
            n_err++; $error("FAIL %s letter_err observed=%b expected=%b", tag, letter_err, m_err);
        end
        n_cmp++;
        assert (word_sep === m_sep) else begin
            n_err++; $error("FAIL %s word_sep observed=%b expected=%b", tag, word_sep, m_sep);
        end
        n_cmp++;
        assert (sym_count === 3'(m_seq.len())) else begin
            n_err++; $error("FAIL %s sym_count observed=%0d expected=%0d", tag, sym_count, m_seq.len());
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic step(input bit d, input bit da, input string tag);
        dot  = d;
        dash = da;
        @(posedge Clock);
        model_edge(d, da);
        #1;
        if (word_sep === 1'b1) sep_seen++;
        check_outputs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
    endtask

    initial begin
        int r;
        Reset = 1'b1; dot = 1'b0; dash = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check_outputs("reset_held");
        Reset = 1'b0;

        // A: dot at edge 3, dash at edge 4, then the letter gap
        step(1, 0, "A_dot");
        step(0, 1, "A_dash");
        idle(3, "A_gap");
        n_cmp++;
        assert (letter === 5'd0 && sym_count === 3'd0) else begin
            n_err++; $error("FAIL A_result letter observed=%0d expected=0", letter);
        end

        // B then a single word separator during continued silence
        step(0, 1, "B_sym"); step(1, 0, "B_sym"); step(1, 0, "B_sym"); step(1, 0, "B_sym");
        sep_seen = 0;
        idle(14, "B_gap");
        n_cmp++;
        assert (sep_seen == 1) else begin
            n_err++; $error("FAIL B_word_sep_count observed=%0d expected=1", sep_seen);
        end

        // Overflow: five dots, letter must keep B
        for (int i = 0; i < 5; i++) step(1, 0, "ovf_sym");
        idle(8, "ovf_gap");
        n_cmp++;
        assert (letter === 5'd1) else begin
            n_err++; $error("FAIL ovf_letter_hold observed=%0d expected=1", letter);
        end

        // Illegal 4-symbol pattern ..--
        step(1, 0, "ill"); step(1, 0, "ill"); step(0, 1, "ill"); step(0, 1, "ill");
        idle(8, "ill_gap");

        // Simultaneous dot and dash
        step(1, 1, "both");
        idle(8, "both_gap");

        // Dot exactly on the gap boundary extends the letter: dash-dot = N
        step(0, 1, "N_dash");
        idle(LG - 1, "N_wait");
        step(1, 0, "N_dot");
        idle(8, "N_gap");
        n_cmp++;
        assert (letter === 5'd13) else begin
            n_err++; $error("FAIL N_result observed=%0d expected=13", letter);
        end

        // Asynchronous reset in the middle of a letter
        step(1, 0, "mid"); step(0, 1, "mid");
        #2;
        Reset = 1'b1; dot = 1'b0; dash = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        #1;
        Reset = 1'b0;
        step(0, 1, "T_dash");
        idle(8, "T_gap");
        n_cmp++;
        assert (letter === 5'd19) else begin
            n_err++; $error("FAIL T_result observed=%0d expected=19", letter);
        end

        // Random keying with occasional long silences
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 5)        step(1, 0, "rnd");
            else if (r < 10)  step(0, 1, "rnd");
            else if (r == 10) step(1, 1, "rnd");
            else if (r == 11) idle(int'($urandom_range(LG, WG + 3)), "rnd_long");
            else              step(0, 0, "rnd");
        end
        idle(10, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_morse_decoder
`default_nettype wire
